game_frame_renderer: RTL and testbench



---
 rtl/game_pkg.sv | 26 ++
 rtl/game_frame_renderer_rect_hit.sv | 12 +
 rtl/game_frame_renderer.sv | 136 +++++++++++++
 tb/tb_game_frame_renderer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants, colours, FSM state type and the snapshot clamp helper
// used by the flappy-bird frame renderer.
package game_pkg;
  localparam int DEF_COORD_W   = 10;
  localparam int DEF_H_RES     = 640;
  localparam int DEF_V_RES     = 480;
  localparam int DEF_BIRD_X    = 160;
  localparam int DEF_BIRD_SIZE = 16;
  localparam int DEF_PIPE_W    = 52;
  localparam int DEF_GAP_H     = 120;
  localparam int DEF_GROUND_Y  = 448;

  localparam logic [23:0] SKY    = 24'h70C0F0;
  localparam logic [23:0] PIPE   = 24'h00A000;
  localparam logic [23:0] GROUND = 24'h805020;
  localparam logic [23:0] BIRD   = 24'hFFD000;

  typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

  function automatic logic signed [11:0] clamp12(input logic signed [31:0] v,
                                                 input int lo, input int hi);
    if (v < lo) return 12'(lo);
    if (v > hi) return 12'(hi);
    return v[11:0];
  endfunction
endpackage

// File: rtl/game_frame_renderer_rect_hit.sv
// Signed 12-bit point-in-half-open-rectangle test: [x_lo,x_hi) x [y_lo,y_hi).
module rect_hit (
  input  logic signed [11:0] px,
  input  logic signed [11:0] py,
  input  logic signed [11:0] x_lo,
  input  logic signed [11:0] x_hi,
  input  logic signed [11:0] y_lo,
  input  logic signed [11:0] y_hi,
  output logic               hit
);
  assign hit = (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);
endmodule

// File: rtl/game_frame_renderer.sv
// Two-stage pixel colour pipeline for the flappy-bird scene with a per-frame
// game-state snapshot and a sticky collision flag.
module game_frame_renderer
  import game_pkg::*;
#(
  parameter int COORD_W   = DEF_COORD_W,
  parameter int H_RES     = DEF_H_RES,
  parameter int V_RES     = DEF_V_RES,
  parameter int BIRD_X    = DEF_BIRD_X,
  parameter int BIRD_SIZE = DEF_BIRD_SIZE,
  parameter int PIPE_W    = DEF_PIPE_W,
  parameter int GAP_H     = DEF_GAP_H,
  parameter int GROUND_Y  = DEF_GROUND_Y
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [31:0]        bird_y,
  input  logic [31:0]        pipe_x,
  input  logic [31:0]        gap_y,
  input  logic               collision_ack,
  output logic               rgb_valid,
  output logic [7:0]         r_data,
  output logic [7:0]         g_data,
  output logic [7:0]         b_data,
  output logic               collision,
  output logic [15:0]        frame_count
);
  localparam logic signed [11:0] C_MIN = 12'sh800;
  localparam logic signed [11:0] C_MAX = 12'sh7FF;

  state_t state;
  logic signed [11:0] snap_bird, snap_pipe, snap_gap;
  logic signed [11:0] px, py;
  logic in_bird, pipe_col, in_gap, in_pipe, in_ground;
  logic s1_valid, s1_active, s1_bird, s1_pipe, s1_ground, s1_folded;
  logic hit_acc, s0_hit, s1_new, set_hit;
  logic [23:0] colour;

  assign px = 12'(pix_x);
  assign py = 12'(pix_y);

  rect_hit u_bird (
    .px(px), .py(py),
    .x_lo(12'(BIRD_X)), .x_hi(12'(BIRD_X + BIRD_SIZE)),
    .y_lo(snap_bird), .y_hi(snap_bird + 12'(BIRD_SIZE)),
    .hit(in_bird)
  );

  rect_hit u_pipe (
    .px(px), .py(py),
    .x_lo(snap_pipe), .x_hi(snap_pipe + 12'(PIPE_W)),
    .y_lo(C_MIN), .y_hi(C_MAX),
    .hit(pipe_col)
  );

  rect_hit u_gap (
    .px(px), .py(py),
    .x_lo(C_MIN), .x_hi(C_MAX),
    .y_lo(snap_gap), .y_hi(snap_gap + 12'(GAP_H)),
    .hit(in_gap)
  );

  assign in_pipe   = pipe_col && !in_gap;
  assign in_ground = py >= 12'(GROUND_Y);

  // A pixel presented with frame_start belongs to the closing frame, so its
  // hit is folded combinationally and flagged to keep it out of the new frame.
  assign s0_hit  = pix_valid && (state == ACTIVE) && in_bird && (in_pipe || in_ground);
  assign s1_new  = s1_valid && s1_active && s1_bird && (s1_pipe || s1_ground) && !s1_folded;
  assign set_hit = hit_acc || s1_new || s0_hit;

  always_comb begin
    colour = '0;
    if (s1_active) begin
      if (s1_bird)        colour = BIRD;
      else if (s1_ground) colour = GROUND;
      else if (s1_pipe)   colour = PIPE;
      else                colour = SKY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= WAIT_FRAME;
      snap_bird   <= '0;
      snap_pipe   <= '0;
      snap_gap    <= '0;
      s1_valid    <= 1'b0;
      s1_active   <= 1'b0;
      s1_bird     <= 1'b0;
      s1_pipe     <= 1'b0;
      s1_ground   <= 1'b0;
      s1_folded   <= 1'b0;
      rgb_valid   <= 1'b0;
      r_data      <= '0;
      g_data      <= '0;
      b_data      <= '0;
      hit_acc     <= 1'b0;
      collision   <= 1'b0;
      frame_count <= '0;
    end else begin
      s1_valid  <= pix_valid;
      s1_active <= (state == ACTIVE);
      s1_bird   <= in_bird;
      s1_pipe   <= in_pipe;
      s1_ground <= in_ground;
      s1_folded <= frame_start;

      rgb_valid <= s1_valid;
      r_data    <= s1_valid ? colour[23:16] : '0;
      g_data    <= s1_valid ? colour[15:8]  : '0;
      b_data    <= s1_valid ? colour[7:0]   : '0;

      if (frame_start) begin
        case (state)
          WAIT_FRAME: state <= ACTIVE;
          default:    state <= ACTIVE;
        endcase
        snap_bird   <= clamp12($signed(bird_y), 0, V_RES - BIRD_SIZE);
        snap_gap    <= clamp12($signed(gap_y), 0, V_RES - GAP_H);
        snap_pipe   <= clamp12($signed(pipe_x), -PIPE_W, H_RES);
        frame_count <= frame_count + 16'd1;
        hit_acc     <= 1'b0;
        if (set_hit)            collision <= 1'b1;
        else if (collision_ack) collision <= 1'b0;
      end else begin
        hit_acc <= hit_acc || s1_new;
        if (collision_ack) collision <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_game_frame_renderer.sv
// Randomized and directed bench for game_frame_renderer against a per-pixel
// behavioural model of the scene and per-frame collision bookkeeping.
module tb_game_frame_renderer;
  import game_pkg::*;

  logic        clock = 1'b0;
  logic        reset, frame_start, pix_valid, collision_ack;
  logic [9:0]  pix_x, pix_y;
  logic [31:0] bird_y, pipe_x, gap_y;
  logic        rgb_valid, collision;
  logic [7:0]  r_data, g_data, b_data;
  logic [15:0] frame_count;

  int vectors = 0;
  int miscompares = 0;

  int m_bird, m_pipe, m_gap, m_fc, d1_c, o_c;
  bit m_active, m_hit, m_coll, d1_v, o_v;

  game_frame_renderer dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .bird_y(bird_y), .pipe_x(pipe_x), .gap_y(gap_y),
    .collision_ack(collision_ack), .rgb_valid(rgb_valid),
    .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .collision(collision), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic bit bird_at(int x, int y);
    return x >= 160 && x < 176 && y >= m_bird && y < m_bird + 16;
  endfunction

  function automatic bit pipe_at(int x, int y);
    return x >= m_pipe && x < m_pipe + 52 && !(y >= m_gap && y < m_gap + 120);
  endfunction

  function automatic int colour_at(int x, int y);
    if (!m_active)     return 0;
    if (bird_at(x, y)) return 32'hFFD000;
    if (y >= 448)      return 32'h805020;
    if (pipe_at(x, y)) return 32'h00A000;
    return 32'h70C0F0;
  endfunction

  task automatic model_reset();
    m_bird = 0; m_pipe = 0; m_gap = 0; m_fc = 0;
    m_active = 0; m_hit = 0; m_coll = 0;
    d1_v = 0; d1_c = 0; o_v = 0; o_c = 0;
  endtask

  task automatic model_edge();
    int x, y;
    bit h;
    x = int'(pix_x);
    y = int'(pix_y);
    o_v = d1_v;
    o_c = d1_v ? d1_c : 0;
    d1_v = pix_valid;
    d1_c = colour_at(x, y);
    h = pix_valid && m_active && bird_at(x, y) && (pipe_at(x, y) || y >= 448);
    if (frame_start) begin
      if (m_hit || h)         m_coll = 1;
      else if (collision_ack) m_coll = 0;
      m_hit    = 0;
      m_bird   = clampi(int'(bird_y), 0, 464);
      m_gap    = clampi(int'(gap_y), 0, 360);
      m_pipe   = clampi(int'(pipe_x), -52, 640);
      m_active = 1;
      m_fc     = (m_fc + 1) % 65536;
    end else begin
      m_hit = m_hit || h;
      if (collision_ack) m_coll = 0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("rgb_valid", 32'(rgb_valid), 32'(o_v));
    check("rgb", 32'({r_data, g_data, b_data}), 32'(o_c));
    check("collision", 32'(collision), 32'(m_coll));
    check("frame_count", 32'(frame_count), 32'(m_fc));
  endtask

  task automatic expect_pix(input int x, input int y, input int exp);
    pix_valid = 1; pix_x = 10'(x); pix_y = 10'(y);
    step();
    pix_valid = 0;
    step();
    check("pixel_colour", 32'({r_data, g_data, b_data}), 32'(exp));
  endtask

  task automatic new_frame(input int by, input int px, input int gy);
    bird_y = 32'(by); pipe_x = 32'(px); gap_y = 32'(gy);
    frame_start = 1;
    step();
    frame_start = 0;
  endtask

  initial begin
    int fc0;
    reset = 1; frame_start = 0; pix_valid = 0; collision_ack = 0;
    pix_x = '0; pix_y = '0; bird_y = '0; pipe_x = '0; gap_y = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 0;
    check("reset_rgb_valid", 32'(rgb_valid), 32'd0);
    check("reset_rgb", 32'({r_data, g_data, b_data}), 32'd0);
    check("reset_frame_count", 32'(frame_count), 32'd0);

    // Pixels before any frame_start: correct latency, black.
    pix_valid = 1; pix_x = 10'd165; pix_y = 10'd5;
    step();
    check("latency_1", 32'(rgb_valid), 32'd0);
    step();
    check("latency_2", 32'(rgb_valid), 32'd1);
    check("wait_black", 32'({r_data, g_data, b_data}), 32'd0);
    repeat (3) step();
    check("wait_fc", 32'(frame_count), 32'd0);
    pix_valid = 0;
    step();

    new_frame(100, 400, 200);
    expect_pix(165, 105, 32'hFFD000);
    expect_pix(410, 50, 32'h00A000);
    expect_pix(410, 250, 32'h70C0F0);
    expect_pix(10, 460, 32'h805020);

    new_frame(440, 400, 200);
    expect_pix(165, 450, 32'hFFD000);
    new_frame(440, 400, 200);
    check("coll_set", 32'(collision), 32'd1);
    collision_ack = 1;
    step();
    collision_ack = 0;
    check("coll_ack", 32'(collision), 32'd0);

    // Hit on the pixel coincident with frame_start and collision_ack.
    pix_valid = 1; pix_x = 10'd165; pix_y = 10'd450;
    collision_ack = 1; frame_start = 1;
    step();
    pix_valid = 0; collision_ack = 0; frame_start = 0;
    check("coll_set_wins", 32'(collision), 32'd1);
    collision_ack = 1;
    step();
    collision_ack = 0;
    step();

    new_frame(-20, -100, 200);
    expect_pix(0, 0, 32'h70C0F0);
    expect_pix(160, 0, 32'hFFD000);

    for (int i = 0; i < 4000; i++) begin
      pix_valid = 1'($urandom_range(0, 3) != 0);
      pix_x = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(150, 185))
                                          : 10'($urandom_range(0, 1023));
      pix_y = 10'($urandom_range(0, 1023));
      collision_ack = 1'($urandom_range(0, 19) == 0);
      frame_start = 1'($urandom_range(0, 49) == 0);
      if (frame_start) begin
        bird_y = 32'(int'($urandom_range(0, 570)) - 50);
        pipe_x = 32'(int'($urandom_range(0, 850)) - 150);
        gap_y  = 32'(int'($urandom_range(0, 500)) - 50);
      end
      step();
    end
    pix_valid = 0; collision_ack = 0; frame_start = 0;
    step();

    fc0 = int'(frame_count);
    frame_start = 1;
    repeat (65536) step();
    frame_start = 0;
    check("fc_wrap", 32'(frame_count), 32'(fc0));

    pix_valid = 1;
    repeat (3) step();
    #2 reset = 1;
    #1;
    check("midreset_valid", 32'(rgb_valid), 32'd0);
    check("midreset_rgb", 32'({r_data, g_data, b_data}), 32'd0);
    pix_valid = 0;
    @(posedge clock);
    #1 reset = 0;
    model_reset();
    repeat (3) step();
    check("post_reset_fc", 32'(frame_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
